ram_extreme_scan: RTL and testbench
===================================

Name: ram_extreme_scan

Overview:
- Parametrised successor of the team's RAM maximum finder.
- Internal simple dual-port RAM with an external write port and an internal sequential read scanner.
- On `start`, scans entries 0..len-1 and reports the extreme value and its address.
- Extreme is maximum or minimum, with a selectable tie policy. Results are returned with a start/busy/done handshake.
- Sits between a data-capture front end (writer) and downstream control logic (consumer of extreme value/address).

Parameters:
- DATA_W, 8, width of stored data words (unsigned).
- ADDR_W, 8, RAM address width; depth DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- start  in  1  scan request; sampled only in IDLE.
- len  in  ADDR_W+1  number of entries to scan from address 0; values > DEPTH clamp to DEPTH.
- find_min  in  1  0 = maximum, 1 = minimum.
- tie_last  in  1  0 = keep first address on equal values, 1 = keep last.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse when result is valid.
- empty  out  1  result flag: scan had len = 0.
- ext_val  out  DATA_W  extreme value found.
- ext_addr  out  ADDR_W  address of extreme value.
- wr_drop  out  1  one-cycle pulse: write ignored because busy.

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, scan counter 0. No RAM contents reset; RAM contents undefined until written.
- RAM:
  - Writes take effect at the clk edge with wr_en=1, only when busy=0.
  - wr_en=1 while busy=1: write discarded, wr_drop=1 the following cycle.
  - Read is synchronous: data for an address issued in cycle N is available in cycle N+1.
- FSM states: IDLE, READ, FLUSH, DONE.
- IDLE:
  - start=1 latches find_min, tie_last, and clamped len (len_q).
  - If len_q=0, go to DONE with empty=1, ext_val=0, ext_addr=0.
  - Otherwise go to READ, busy=1.
  - start outside IDLE is ignored; no queueing.
- READ:
  - Issues read addresses 0,1,...,len_q-1, one per cycle.
  - After issuing address len_q-1, go to FLUSH.
- FLUSH: one cycle for the last RAM read to return; then go to DONE.
- Compare pipeline (one registered stage): on each returned word q with its delayed address a:
  - First word of a scan unconditionally loads ext_val=q, ext_addr=a.
  - Subsequent words, max mode: update if q>ext_val, or q==ext_val and tie_last=1.
  - Subsequent words, min mode: update if q<ext_val, or q==ext_val and tie_last=1.
  - Comparisons are unsigned, full DATA_W.
- DONE:
  - done=1 for one cycle; busy=0 from this cycle; return to IDLE.
  - ext_val, ext_addr, empty hold until the next accepted start.
  - empty clears on the next accepted start.
- Timing:
  - start sampled at edge E → busy high from E.
  - For len_q>0, done high in the cycle after edge E+len_q+2, i.e. latency len_q+2 cycles.
  - For len=0, done asserts exactly 1 cycle after E.
  - Back-to-back: start may be asserted in the cycle after done; it is accepted.
- A write in the same cycle as an accepted start (busy still 0) is committed before the scan reads it. This holds because the scan reads address 0 no earlier than the next cycle.
- len = DEPTH: scans full RAM, address counter wraps internally without an extra read; ext_addr max DEPTH-1.
- Reset mid-scan: immediately IDLE, busy=0, done=0, results cleared to 0; RAM contents retained.

Test Plan:
- Write addr k ← k%9 for k=0..99. start, len=100, max, tie_first → done after 102 cycles, ext_val=8, ext_addr=8.
- Same data, tie_last=1 → ext_val=8, ext_addr=98. Min with tie_last=0 → ext_val=0, ext_addr=0. Min with tie_last=1 → ext_val=0, ext_addr=99.
- len=0 → done 1 cycle after start, empty=1, ext_val=0, ext_addr=0; a following start with len=1 (addr0=0x5A) → empty=0, ext_val=0x5A, ext_addr=0, latency 3.
- len=300 with ADDR_W=8, RAM filled with 0xFF-addr except addr 200=0xFF → clamped to 256, latency 258, max ext_val=0xFF, ext_addr=0 (tie_first); tie_last → ext_addr=200.
- wr_en pulsed during busy to addr 3 with 0xFF → wr_drop pulses, result unaffected, later read confirms old addr 3 value. start pulsed during busy is ignored: only one done.
- rst_n low mid-scan at cycle 20 → busy/done/ext_* = 0 asynchronously. Rescan after release gives the same result as the pre-reset data.

Source files
------------

// File: rtl/ram_extreme_scan.sv
// RAM extreme-value scanner: external write port, internal sequential read scan,
// reports the max/min word and its address over entries 0..len-1.
module ram_extreme_scan #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              find_min,
    input  logic              tie_last,
    output logic              busy,
    output logic              done,
    output logic              empty,
    output logic [DATA_W-1:0] ext_val,
    output logic [ADDR_W-1:0] ext_addr,
    output logic              wr_drop
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_valid;
    logic              first_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_clamp;
    logic              find_min_q;
    logic              tie_last_q;
    logic              accept;
    logic              last_issue;
    logic              better;

    assign len_clamp  = (len > DEPTH_LEN) ? DEPTH_LEN : len;
    assign accept     = (state == S_IDLE) && start;
    // Compared in ADDR_W+1 bits so a full-depth scan ends at DEPTH-1 and rd_ptr simply wraps.
    assign last_issue = ({1'b0, rd_ptr} == (len_q - (ADDR_W+1)'(1)));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        better = 1'b0;
        if (find_min_q)
            better = (rd_data < ext_val) || ((rd_data == ext_val) && tie_last_q);
        else
            better = (rd_data > ext_val) || ((rd_data == ext_val) && tie_last_q);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = (len_clamp == '0) ? S_DONE : S_READ;
            S_READ:  if (last_issue) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the RAM array and its read register carry no reset so they can map onto block RAM;
    // contents survive rst_n and are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_ptr];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            rd_addr_q  <= '0;
            rd_valid   <= 1'b0;
            first_q    <= 1'b0;
            len_q      <= '0;
            find_min_q <= 1'b0;
            tie_last_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_valid  <= (state == S_READ);
            rd_addr_q <= rd_ptr;
            if (accept) begin
                len_q      <= len_clamp;
                find_min_q <= find_min;
                tie_last_q <= tie_last;
                rd_ptr     <= '0;
                first_q    <= 1'b1;
            end else if (state == S_READ) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (rd_valid)
                first_q <= 1'b0;
        end
    end

    // Result registers: cleared on an accepted start, then fed by the one-stage compare pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            empty    <= 1'b0;
            ext_val  <= '0;
            ext_addr <= '0;
            wr_drop  <= 1'b0;
        end else begin
            done    <= (state == S_DONE);
            wr_drop <= wr_en && busy;
            if (accept) begin
                busy     <= 1'b1;
                empty    <= (len_clamp == '0);
                ext_val  <= '0;
                ext_addr <= '0;
            end else if (state == S_DONE) begin
                busy <= 1'b0;
            end
            if (rd_valid && (first_q || better)) begin
                ext_val  <= rd_data;
                ext_addr <= rd_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_extreme_scan.sv
// Self-checking bench for ram_extreme_scan: directed scenarios with literal expectations
// plus randomized scans compared cycle by cycle against a behavioural model.
module tb_ram_extreme_scan;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic [8:0] len = '0;
    logic       find_min = 1'b0;
    logic       tie_last = 1'b0;
    logic       busy, done, empty, wr_drop;
    logic [7:0] ext_val, ext_addr;

    ram_extreme_scan #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .len      (len),
        .find_min (find_min),
        .tie_last (tie_last),
        .busy     (busy),
        .done     (done),
        .empty    (empty),
        .ext_val  (ext_val),
        .ext_addr (ext_addr),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [DEPTH];
    bit         m_busy = 1'b0, m_done = 1'b0, m_wr_drop = 1'b0;
    bit         m_res_valid = 1'b1, m_empty = 1'b0, p_empty = 1'b0;
    logic [7:0] m_val = '0, m_addr = '0, p_val = '0, p_addr = '0;
    int         m_cnt = 0;
    bit         was_busy;
    int         n_acc;

    function automatic int clamp_len(input logic [8:0] l);
        return (l > 9'd256) ? 256 : int'(l);
    endfunction

    // Extreme value first, then first/last index holding it.
    function automatic void ref_extreme(input int n, input bit fmin, input bit tl,
                                        output logic [7:0] v, output logic [7:0] a);
        int best;
        bit found;
        best  = fmin ? 256 : -1;
        found = 1'b0;
        a     = '0;
        for (int i = 0; i < n; i++) begin
            int d = int'(m_mem[i]);
            if (fmin ? (d < best) : (d > best)) best = d;
        end
        for (int i = 0; i < n; i++) begin
            if (int'(m_mem[i]) == best) begin
                if (!found || tl) a = 8'(i);
                found = 1'b1;
            end
        end
        v = (n == 0) ? 8'h00 : 8'(best);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_wr_drop = 1'b0; m_cnt = 0;
            m_res_valid = 1'b1; m_val = '0; m_addr = '0; m_empty = 1'b0;
        end else begin
            was_busy  = m_busy;
            m_done    = 1'b0;
            m_wr_drop = wr_en && was_busy;
            if (wr_en && !was_busy) m_mem[wr_addr] = wr_data;
            if (was_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_res_valid = 1'b1;
                    m_val = p_val; m_addr = p_addr; m_empty = p_empty;
                end
            end else if (start) begin
                n_acc = clamp_len(len);
                ref_extreme(n_acc, find_min, tie_last, p_val, p_addr);
                p_empty     = (n_acc == 0);
                m_busy      = 1'b1;
                m_cnt       = (n_acc == 0) ? 1 : n_acc + 2;
                m_res_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("wr_drop", wr_drop, m_wr_drop);
            if (m_res_valid) begin
                check("ext_val", ext_val, m_val);
                check("ext_addr", ext_addr, m_addr);
                check("empty", empty, m_empty);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_write(input int a, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a[7:0]; wr_data = d[7:0];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns the number of edges from the accepting edge to the edge after which done is high.
    task automatic run_scan(input int l, input bit fmin, input bit tl, input bit disturb,
                            output int lat);
        @(negedge clk);
        start = 1'b1; len = l[8:0]; find_min = fmin; tie_last = tl;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 400) begin
            if (disturb) begin
                wr_en   = ($urandom_range(0, 5) == 0);
                wr_addr = 8'($urandom_range(0, 63));
                wr_data = 8'($urandom_range(0, 15));
                start   = ($urandom_range(0, 7) == 0);
                len     = 9'($urandom_range(0, 300));
            end
            @(posedge clk);
            lat++;
            #1;
            if (done === 1'b1) break;
        end
        wr_en = 1'b0; start = 1'b0;
        if (lat >= 400) check("scan_timeout", 32'(lat), 32'(0));
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int n;
        int cnt_done;

        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_empty", empty, 1'b0);
        check("rst_ext_val", ext_val, 8'h00);
        check("rst_ext_addr", ext_addr, 8'h00);
        check("rst_wr_drop", wr_drop, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) do_write(a, int'($urandom_range(0, 255)));
        for (int k = 0; k < 100; k++) do_write(k, k % 9);

        run_scan(100, 1'b0, 1'b0, 1'b0, lat);
        check("max_first_lat", lat, 102);
        check("max_first_val", ext_val, 8'd8);
        check("max_first_addr", ext_addr, 8'd8);
        run_scan(100, 1'b0, 1'b1, 1'b0, lat);
        check("max_last_val", ext_val, 8'd8);
        check("max_last_addr", ext_addr, 8'd98);
        run_scan(100, 1'b1, 1'b0, 1'b0, lat);
        check("min_first_val", ext_val, 8'd0);
        check("min_first_addr", ext_addr, 8'd0);
        run_scan(100, 1'b1, 1'b1, 1'b0, lat);
        check("min_last_val", ext_val, 8'd0);
        check("min_last_addr", ext_addr, 8'd99);

        run_scan(0, 1'b0, 1'b0, 1'b0, lat);
        check("len0_lat", lat, 1);
        check("len0_empty", empty, 1'b1);
        check("len0_val", ext_val, 8'h00);
        check("len0_addr", ext_addr, 8'h00);
        do_write(0, 'h5A);
        run_scan(1, 1'b0, 1'b0, 1'b0, lat);
        check("len1_lat", lat, 3);
        check("len1_empty", empty, 1'b0);
        check("len1_val", ext_val, 8'h5A);
        check("len1_addr", ext_addr, 8'h00);

        for (int a = 0; a < DEPTH; a++) do_write(a, 255 - a);
        do_write(200, 'hFF);
        run_scan(300, 1'b0, 1'b0, 1'b0, lat);
        check("clamp_lat", lat, 258);
        check("clamp_val", ext_val, 8'hFF);
        check("clamp_addr_first", ext_addr, 8'd0);
        run_scan(300, 1'b0, 1'b1, 1'b0, lat);
        check("clamp_addr_last", ext_addr, 8'd200);

        // Write and start attempts while busy must be dropped/ignored.
        @(negedge clk);
        start = 1'b1; len = 9'd10; find_min = 1'b0; tie_last = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 wr_en = 1'b0; start = 1'b0;
        check("busy_wr_drop", wr_drop, 1'b1);
        cnt_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                cnt_done++;
                if (cnt_done == 1) begin
                    check("busy_scan_val", ext_val, 8'hFF);
                    check("busy_scan_addr", ext_addr, 8'd0);
                end
            end
        end
        check("busy_single_done", cnt_done, 1);
        run_scan(4, 1'b1, 1'b0, 1'b0, lat);
        check("old_addr3_val", ext_val, 8'hFC);
        check("old_addr3_addr", ext_addr, 8'd3);

        // Asynchronous reset in the middle of a scan.
        @(negedge clk);
        start = 1'b1; len = 9'd256; find_min = 1'b0; tie_last = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_val", ext_val, 8'h00);
        check("midrst_addr", ext_addr, 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_scan(256, 1'b0, 1'b1, 1'b0, lat);
        check("post_rst_lat", lat, 258);
        check("post_rst_val", ext_val, 8'hFF);
        check("post_rst_addr", ext_addr, 8'd200);

        // Randomized scans over small-valued data so ties are frequent.
        for (int a = 0; a < 64; a++) do_write(a, int'($urandom_range(0, 15)));
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 6))
                do_write(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 300))
                                            : int'($urandom_range(0, 64));
            run_scan(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), lat);
            check("rand_lat", lat, (clamp_len(9'(n)) == 0) ? 1 : clamp_len(9'(n)) + 2);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
